// File: rtl/pic_pkg.sv
// Shared types and OCW2 opcodes for the PIC acknowledge sequencer.
package pic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK1  = 2'd1,
    ST_WAIT2 = 2'd2,
    ST_ACK2  = 2'd3
  } pic_state_e;

  localparam logic [2:0] OCW2_CLR_ROT    = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
  localparam logic [2:0] OCW2_NOP        = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI     = 3'b011;
  localparam logic [2:0] OCW2_SET_ROT    = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI    = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI = 3'b111;

  // Rank 0 is the highest priority; the level just above lp owns rank 0.
  function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lp);
    return 3'(lvl - lp - 3'd1);
  endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Rotating priority encoder: returns the highest-ranked set level given lp.
module pic_prio_enc (
  input  logic [7:0] vec,
  input  logic [2:0] lp,
  output logic       valid_c,
  output logic [2:0] level_c
);

  // Walk from lowest rank to highest so the highest-ranked hit lands last.
  always_comb begin
    valid_c = 1'b0;
    level_c = 3'd7;
    for (int k = 7; k >= 0; k--) begin
      if (vec[lp + 3'd1 + 3'(k)]) begin
        valid_c = 1'b1;
        level_c = lp + 3'd1 + 3'(k);
      end
    end
  end

endmodule

// File: rtl/pic_ack_sequencer.sv
// 8259-style two-pulse INTA sequencer with rotating priority, fully nested ISR and OCW2 EOI handling.
module pic_ack_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned VEC_BASE_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            irr,
  input  logic [7:0]            imr,
  input  logic                  inta_n,
  input  logic [VEC_BASE_W-1:0] vec_base,
  input  logic                  aeoi,
  input  logic                  ocw2_wr,
  input  logic [2:0]            ocw2_cmd,
  input  logic [2:0]            ocw2_lvl,
  output logic                  int_out,
  output logic [7:0]            isr,
  output logic [7:0]            irr_clr,
  output logic [7:0]            data_out,
  output logic                  data_oe
);

  pic_state_e state, state_d;
  logic       inta_q;
  logic [2:0] lp, lp_d;
  logic       rot_aeoi, rot_aeoi_d;
  logic [2:0] winner, winner_d;
  logic       spurious, spurious_d;
  logic [7:0] isr_d, isr_set, isr_clr;
  logic [7:0] irr_clr_d, data_out_d;
  logic       data_oe_d, int_out_d;

  logic       isr_valid_c, elig_valid_c;
  logic [2:0] isr_lvl_c, elig_lvl_c;
  logic [7:0] nest_mask_c, eligible_c;
  logic       inta_fall_c, inta_rise_c;

  assign inta_fall_c = inta_q & ~inta_n;
  assign inta_rise_c = ~inta_q & inta_n;

  pic_prio_enc u_isr_enc (
    .vec     (isr),
    .lp      (lp),
    .valid_c (isr_valid_c),
    .level_c (isr_lvl_c)
  );

  // Fully nested: only levels ranked strictly above the top in-service level may interrupt.
  always_comb begin
    nest_mask_c = '0;
    for (int i = 0; i < 8; i++) begin
      nest_mask_c[i] = !isr_valid_c || (prio_rank(3'(i), lp) < prio_rank(isr_lvl_c, lp));
    end
  end

  assign eligible_c = irr & ~imr & nest_mask_c;

  pic_prio_enc u_irr_enc (
    .vec     (eligible_c),
    .lp      (lp),
    .valid_c (elig_valid_c),
    .level_c (elig_lvl_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      inta_q   <= 1'b1;
      isr      <= '0;
      lp       <= 3'd7;
      rot_aeoi <= 1'b0;
      winner   <= 3'd7;
      spurious <= 1'b0;
      irr_clr  <= '0;
      data_out <= '0;
      data_oe  <= 1'b0;
      int_out  <= 1'b0;
    end else begin
      state    <= state_d;
      inta_q   <= inta_n;
      isr      <= isr_d;
      lp       <= lp_d;
      rot_aeoi <= rot_aeoi_d;
      winner   <= winner_d;
      spurious <= spurious_d;
      irr_clr  <= irr_clr_d;
      data_out <= data_out_d;
      data_oe  <= data_oe_d;
      int_out  <= int_out_d;
    end
  end

  always_comb begin
    state_d    = state;
    lp_d       = lp;
    rot_aeoi_d = rot_aeoi;
    winner_d   = winner;
    spurious_d = spurious;
    isr_set    = '0;
    isr_clr    = '0;
    irr_clr_d  = '0;

    unique case (state)
      ST_IDLE: begin
        if (inta_fall_c) begin
          state_d    = ST_ACK1;
          winner_d   = elig_lvl_c;
          spurious_d = !elig_valid_c;
          if (elig_valid_c) begin
            isr_set[elig_lvl_c]   = 1'b1;
            irr_clr_d[elig_lvl_c] = 1'b1;
          end
        end
      end
      ST_ACK1:  if (inta_rise_c) state_d = ST_WAIT2;
      ST_WAIT2: if (inta_fall_c) state_d = ST_ACK2;
      ST_ACK2: begin
        if (inta_rise_c) begin
          state_d = ST_IDLE;
          if (aeoi && !spurious) begin
            isr_clr[winner] = 1'b1;
            if (rot_aeoi) lp_d = winner;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // OCW2 acts on the pre-cycle ISR; an explicit lp write overrides AEOI rotation.
    if (ocw2_wr) begin
      case (ocw2_cmd)
        OCW2_NS_EOI: if (isr_valid_c) isr_clr[isr_lvl_c] = 1'b1;
        OCW2_SP_EOI: isr_clr[ocw2_lvl] = 1'b1;
        OCW2_ROT_NS_EOI: begin
          if (isr_valid_c) begin
            isr_clr[isr_lvl_c] = 1'b1;
            lp_d               = isr_lvl_c;
          end
        end
        OCW2_ROT_SP_EOI: begin
          isr_clr[ocw2_lvl] = 1'b1;
          lp_d              = ocw2_lvl;
        end
        OCW2_SET_PRI: lp_d       = ocw2_lvl;
        OCW2_SET_ROT: rot_aeoi_d = 1'b1;
        OCW2_CLR_ROT: rot_aeoi_d = 1'b0;
        default: ;
      endcase
    end

    isr_d      = (isr & ~isr_clr) | isr_set;
    data_oe_d  = (state_d == ST_ACK2);
    data_out_d = (state_d == ST_ACK2) ? 8'({vec_base, winner_d}) : 8'd0;
    int_out_d  = (state_d == ST_IDLE) && elig_valid_c;
  end

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Directed bench for pic_ack_sequencer: INTA sequences, nesting, OCW2 EOI/rotation, AEOI and reset abort.
module tb_pic_ack_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irr, imr;
  logic       inta_n;
  logic [4:0] vec_base;
  logic       aeoi, ocw2_wr;
  logic [2:0] ocw2_cmd, ocw2_lvl;
  logic       int_out, data_oe;
  logic [7:0] isr, irr_clr, data_out;

  int         passed = 0;
  int         total  = 0;
  logic [7:0] clr_or, vec_seen;
  int         clr_cnt, oe_cnt;

  always #5 clk = ~clk;

  pic_ack_sequencer #(.VEC_BASE_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .irr      (irr),
    .imr      (imr),
    .inta_n   (inta_n),
    .vec_base (vec_base),
    .aeoi     (aeoi),
    .ocw2_wr  (ocw2_wr),
    .ocw2_cmd (ocw2_cmd),
    .ocw2_lvl (ocw2_lvl),
    .int_out  (int_out),
    .isr      (isr),
    .irr_clr  (irr_clr),
    .data_out (data_out),
    .data_oe  (data_oe)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (irr_clr != 8'h00) begin
      clr_cnt++;
      clr_or = clr_or | irr_clr;
    end
    if (data_oe) begin
      oe_cnt++;
      vec_seen = data_out;
    end
  endtask

  // n INTA pulses, each held low 3 cycles then high 3 cycles, recording irr_clr and vector activity.
  task automatic inta_seq(input int n);
    clr_or   = 8'h00;
    clr_cnt  = 0;
    vec_seen = 8'h00;
    oe_cnt   = 0;
    for (int p = 0; p < n; p++) begin
      inta_n = 1'b0;
      repeat (3) begin tick(); sample(); end
      inta_n = 1'b1;
      repeat (3) begin tick(); sample(); end
    end
  endtask

  task automatic ocw2(input logic [2:0] cmd, input logic [2:0] lvl);
    ocw2_wr  = 1'b1;
    ocw2_cmd = cmd;
    ocw2_lvl = lvl;
    tick();
    ocw2_wr  = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; irr = 8'h00; imr = 8'h00; inta_n = 1'b1; vec_base = 5'h08;
    aeoi = 1'b0; ocw2_wr = 1'b0; ocw2_cmd = 3'd0; ocw2_lvl = 3'd0;
    repeat (3) tick();
    chk("rst_int_out", 32'(int_out), 32'h0);
    chk("rst_isr", 32'(isr), 32'h00);
    chk("rst_irr_clr", 32'(irr_clr), 32'h00);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_data_oe", 32'(data_oe), 32'h0);
    rst = 1'b0;

    // Default priority lp=7: IR2 beats IR5.
    irr = 8'h24;
    tick(); tick();
    chk("pend_int_out", 32'(int_out), 32'h1);
    inta_seq(2);
    chk("ack_clr_mask", 32'(clr_or), 32'h04);
    chk("ack_clr_once", 32'(clr_cnt), 32'd1);
    chk("ack_isr", 32'(isr), 32'h04);
    chk("ack_vector", 32'(vec_seen), 32'h42);
    chk("ack_oe_cycles", 32'(oe_cnt), 32'd3);
    chk("nested_block", 32'(int_out), 32'h0);

    irr = 8'h01; tick(); tick();
    chk("nest_higher", 32'(int_out), 32'h1);
    irr = 8'h10; tick(); tick();
    chk("nest_lower", 32'(int_out), 32'h0);

    ocw2(3'b001, 3'd0);
    chk("ns_eoi_isr", 32'(isr), 32'h00);

    irr = 8'h08; tick();
    inta_seq(2);
    chk("ir3_vector", 32'(vec_seen), 32'h43);
    chk("ir3_isr", 32'(isr), 32'h08);
    ocw2(3'b101, 3'd0);
    chk("rot_ns_eoi_isr", 32'(isr), 32'h00);

    // lp=3: rank order 4..7,0..3, so IR0 beats IR3.
    irr = 8'h09; tick();
    inta_seq(2);
    chk("rot_vector", 32'(vec_seen), 32'h40);
    chk("rot_isr", 32'(isr), 32'h01);
    ocw2(3'b011, 3'd0);
    chk("sp_eoi_isr", 32'(isr), 32'h00);

    aeoi = 1'b1; irr = 8'h80; tick();
    inta_seq(2);
    chk("aeoi_vector", 32'(vec_seen), 32'h47);
    chk("aeoi_clr", 32'(clr_or), 32'h80);
    chk("aeoi_isr", 32'(isr), 32'h00);

    irr = 8'h00; tick();
    inta_seq(2);
    chk("spur_vector", 32'(vec_seen), 32'h47);
    chk("spur_no_clr", 32'(clr_cnt), 32'd0);
    chk("spur_isr", 32'(isr), 32'h00);

    // Rotate-in-AEOI: IR1 served with lp=3, then lp becomes 1 so IR3 outranks IR1.
    ocw2(3'b100, 3'd0);
    irr = 8'h02; tick();
    inta_seq(2);
    chk("raeoi_vector1", 32'(vec_seen), 32'h41);
    irr = 8'h0A; tick();
    inta_seq(2);
    chk("raeoi_vector2", 32'(vec_seen), 32'h43);
    chk("raeoi_isr", 32'(isr), 32'h00);
    aeoi = 1'b0;
    ocw2(3'b000, 3'd0);

    // Reset abort in WAIT2.
    irr = 8'h01; tick();
    inta_seq(2);
    chk("pre_rst_isr", 32'(isr), 32'h01);
    inta_seq(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_data_oe", 32'(data_oe), 32'h0);
    chk("abort_isr", 32'(isr), 32'h00);
    chk("abort_irr_clr", 32'(irr_clr), 32'h00);
    irr = 8'h00;
    inta_seq(1);
    chk("abort_no_vector", 32'(oe_cnt), 32'd0);
    chk("abort_no_clr", 32'(clr_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pic_ack_sequencer.md
PIC_ACK_SEQUENCER -- requirements
Module: pic_ack_sequencer

Interface
REQ-001 Parameter VEC_BASE_W, default 5, width of the ICW2 vector-base field (T7..T3).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 irr  input  8  interrupt request register contents, bit i = IRi.
REQ-005 imr  input  8  interrupt mask register; 1 masks the level.
REQ-006 inta_n  input  1  CPU acknowledge, active-low, synchronous to clk.
REQ-007 vec_base  input  VEC_BASE_W  ICW2 T7..T3.
REQ-008 aeoi  input  1  automatic-EOI mode enable.
REQ-009 ocw2_wr  input  1  one-cycle OCW2 command strobe.
REQ-010 ocw2_cmd  input  3  {R,SL,EOI} opcode.
REQ-011 ocw2_lvl  input  3  level field L2..L0.
REQ-012 int_out  output  1  interrupt request to CPU.
REQ-013 isr  output  8  in-service register.
REQ-014 irr_clr  output  8  one-cycle pulse clearing the acknowledged IRR bit.
REQ-015 data_out  output  8  vector byte; data_oe  output  1  data-bus drive enable.

Function
REQ-016 Falling edge of inta_n = previous sampled value 1, current 0; rising edge likewise.
REQ-017 Lowest-priority register lp[2:0]; priority rank of level i = (i - lp - 1) mod 8, rank 0 highest.
REQ-018 Eligible set = irr & ~imr, restricted to ranks strictly higher than the highest-ranked set isr bit (fully nested).
REQ-019 int_out = 1 in IDLE when the eligible set is non-zero, else 0.
REQ-020 States: IDLE, ACK1, WAIT2, ACK2.
REQ-021 IDLE -> ACK1 on inta_n falling edge; that cycle latch winner = highest-ranked eligible level, or spurious flag if none.
REQ-022 Non-spurious ACK1 entry cycle: set isr[winner], pulse irr_clr[winner] for exactly one cycle; spurious: no isr or irr_clr change, winner = 7.
REQ-023 ACK1 -> WAIT2 on inta_n rising edge; data_oe = 0 throughout ACK1 and WAIT2.
REQ-024 WAIT2 -> ACK2 on next inta_n falling edge; in ACK2 data_oe = 1, data_out = {vec_base, winner}.
REQ-025 ACK2 -> IDLE on inta_n rising edge; data_oe drops in the IDLE cycle.
REQ-026 On ACK2 exit with aeoi = 1 and non-spurious: clear isr[winner]; if R flag latched by last OCW2 rotate-in-AEOI (cmd 100), set lp = winner.
REQ-027 OCW2 cmd 001 non-specific EOI: clear highest-ranked set isr bit; no-op if isr = 0.
REQ-028 Cmd 011 specific EOI: clear isr[ocw2_lvl].
REQ-029 Cmd 101 rotate on NS-EOI: clear highest-ranked isr bit b, set lp = b; no-op if isr = 0.
REQ-030 Cmd 111 rotate on specific EOI: clear isr[ocw2_lvl], lp = ocw2_lvl.
REQ-031 Cmd 110 set priority: lp = ocw2_lvl; cmd 100 sets, 000 clears, the AEOI-rotate flag; 010 no-op.
REQ-032 Same-cycle OCW2 EOI and ACK1 set on one bit: set wins; EOI evaluated on pre-cycle isr.
REQ-033 inta_n activity while in any non-IDLE state only advances per REQ-023..025; no new winner latched.

Reset
REQ-034 rst forces IDLE, isr = 0, lp = 7, AEOI-rotate flag = 0, int_out = 0, irr_clr = 0, data_out = 0, data_oe = 0, inta_n history = 1.
REQ-035 rst mid-acknowledge aborts the sequence; no irr_clr pulse or vector is issued afterward.

Structure
REQ-036 Shared package pic_pkg holds the state enumeration and OCW2 opcode constants.
REQ-037 Rotating priority encoder (8-bit vector + lp -> valid, level) is sub-module pic_prio_enc, instantiated for eligible-IRR and for ISR.

Verification
REQ-038 irr = 0x24, imr = 0, vec_base = 0x08, two INTA pulses -> irr_clr = 0x04 once, isr = 0x04, data_out = 0x42 on second pulse.
REQ-039 isr = 0x04, irr = 0x01 -> int_out = 1; irr = 0x10 only -> int_out = 0.
REQ-040 OCW2 cmd 101 with isr = 0x08 -> isr = 0, lp = 3; then irr = 0x09 acknowledged -> winner 0 not 3... rank order 4..7,0..3 so winner 0, vector {base,0}.
REQ-041 aeoi = 1, irr = 0x80 -> after second INTA isr = 0; spurious case irr = 0 -> vector {base,7}, isr unchanged.
REQ-042 rst asserted in WAIT2 -> next cycle IDLE, data_oe = 0, isr = 0, subsequent single INTA pulse yields no vector.
